// File: rtl/seg7_scan_reader_if.sv
// Scanned 7-segment display bus: segment lines plus one-hot digit selects.
// The display driver is the master; readers observe as slave.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] dig_sel;

    modport master (output seg_in, output dig_sel);
    modport slave  (input  seg_in, input  dig_sel);
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads back a scanned common-cathode 7-segment display: debounces each digit's
// pattern, decodes it to hex and tracks per-digit validity and illegal patterns.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    seg7_scan_reader_if.slave                              disp,
    input  logic                                           clr_err,
    output logic [4*NUM_DIGITS-1:0]                        hex_out,
    output logic [NUM_DIGITS-1:0]                          digit_valid,
    output logic                                           pattern_err,
    output logic                                           update,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx
);

    localparam int SAMPLE_W = NUM_DIGITS + 7;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hit_q, hit_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    update_q, update_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic                    changed;
    logic [NUM_DIGITS-1:0]   held_sel;
    logic [6:0]              held_seg;
    logic                    sel_onehot;
    logic [IDX_W-1:0]        sel_idx;
    logic [4:0]              decoded;
    logic                    commit;

    // Inverse of the hex-to-7-segment table; bit 4 flags a legal pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = 5'h10;
            7'h30:   r = 5'h11;
            7'h6D:   r = 5'h12;
            7'h79:   r = 5'h13;
            7'h33:   r = 5'h14;
            7'h5B:   r = 5'h15;
            7'h5F:   r = 5'h16;
            7'h70:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h7B:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h1F:   r = 5'h1B;
            7'h4E:   r = 5'h1C;
            7'h3D:   r = 5'h1D;
            7'h4F:   r = 5'h1E;
            7'h47:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // hit fires only on the edge where the run length first reaches the threshold.
    always_comb begin
        sample_d = {disp.dig_sel, disp.seg_in};
        changed  = (sample_d != sample_q);
        if (changed) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        hit_d = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
    end

    always_comb begin
        held_sel   = sample_q[SAMPLE_W-1:7];
        held_seg   = sample_q[6:0];
        sel_onehot = (held_sel != '0) &&
                     ((held_sel & (held_sel - NUM_DIGITS'(1))) == '0);
        sel_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (held_sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        decoded = decode_seg(held_seg);
        commit  = hit_q && sel_onehot;
    end

    // A coincident illegal commit overrides clr_err.
    always_comb begin
        hex_d    = hex_q;
        valid_d  = valid_q;
        err_d    = err_q & ~clr_err;
        update_d = 1'b0;
        idx_d    = idx_q;
        if (commit) begin
            update_d = 1'b1;
            idx_d    = sel_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (held_sel[i]) begin
                    if (decoded[4]) begin
                        hex_d[4*i +: 4] = decoded[3:0];
                        valid_d[i]      = 1'b1;
                    end else begin
                        valid_d[i]      = 1'b0;
                    end
                end
            end
            if (!decoded[4]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            hex_q    <= '0;
            valid_q  <= '0;
            err_q    <= 1'b0;
            update_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            update_q <= update_d;
            idx_q    <= idx_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign pattern_err = err_q;
    assign update      = update_q;
    assign upd_idx     = idx_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomised self-checking bench for seg7_scan_reader against a run-length
// reference model of the scanned display bus.
module tb_seg7_scan_reader;

    localparam int ND    = 4;
    localparam int S     = 4;
    localparam int IDX_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr_err;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_valid;
    logic            pattern_err;
    logic            update;
    logic [IDX_W-1:0] upd_idx;

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) disp ();

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .disp        (disp),
        .clr_err     (clr_err),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .update      (update),
        .upd_idx     (upd_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_upd = 0;

    logic [6:0] legal_pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model state
    logic [3:0]       exp_hex [ND];
    logic [ND-1:0]    exp_valid;
    logic             exp_err;
    logic             exp_upd;
    logic [IDX_W-1:0] exp_idx;
    logic [ND+6:0]    hist [$];

    function automatic int lookup(input logic [6:0] seg);
        for (int i = 0; i < 16; i++) begin
            if (legal_pat[i] == seg) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A commit becomes visible one edge after a run of identical samples
    // (counted since the last reset) first reaches length S.
    task automatic modelEdge(input logic r, input logic [ND-1:0] dsel,
                             input logic [6:0] seg, input logic clr);
        int n;
        int pos;
        int code;
        bit run_ok;
        logic err_next;
        logic [ND+6:0] last;
        if (r) begin
            for (int i = 0; i < ND; i++) exp_hex[i] = 4'h0;
            exp_valid = '0;
            exp_err   = 1'b0;
            exp_upd   = 1'b0;
            exp_idx   = '0;
            hist.delete();
            return;
        end
        exp_upd  = 1'b0;
        err_next = exp_err & ~clr;
        n = hist.size();
        run_ok = 0;
        last = '0;
        if (n >= S) begin
            last   = hist[n-1];
            run_ok = 1;
            for (int k = n - S; k < n; k++) begin
                if (hist[k] != last) run_ok = 0;
            end
            if (n > S && hist[n-S-1] == last) run_ok = 0;
        end
        if (run_ok && $countones(last[ND+6:7]) == 1) begin
            pos = 0;
            for (int i = 0; i < ND; i++) begin
                if (last[7+i]) pos = i;
            end
            code    = lookup(last[6:0]);
            exp_upd = 1'b1;
            exp_idx = IDX_W'(pos);
            if (code >= 0) begin
                exp_hex[pos]   = code[3:0];
                exp_valid[pos] = 1'b1;
            end else begin
                exp_valid[pos] = 1'b0;
                err_next       = 1'b1;
            end
        end
        exp_err = err_next;
        hist.push_back({dsel, seg});
        if (hist.size() > S + 1) void'(hist.pop_front());
    endtask

    task automatic applyStimulus(input logic [ND-1:0] dsel, input logic [6:0] seg,
                                 input logic clr, input logic r);
        logic [4*ND-1:0] exp_packed;
        disp.dig_sel = dsel;
        disp.seg_in  = seg;
        clr_err      = clr;
        rst          = r;
        @(posedge clk);
        modelEdge(r, dsel, seg, clr);
        @(negedge clk);
        for (int i = 0; i < ND; i++) exp_packed[4*i +: 4] = exp_hex[i];
        if (update === 1'b1) dut_upd++;
        checkOutput("hex_out", 32'(hex_out), 32'(exp_packed));
        checkOutput("digit_valid", 32'(digit_valid), 32'(exp_valid));
        checkOutput("pattern_err", 32'(pattern_err), 32'(exp_err));
        checkOutput("update", 32'(update), 32'(exp_upd));
        if (exp_upd) checkOutput("upd_idx", 32'(upd_idx), 32'(exp_idx));
    endtask

    task automatic hold(input logic [ND-1:0] dsel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) applyStimulus(dsel, seg, 1'b0, 1'b0);
    endtask

    initial begin
        logic [ND-1:0] dsel;
        logic [6:0]    seg;
        int            pick;
        int            len;

        applyStimulus('0, 7'h00, 1'b0, 1'b1);
        applyStimulus('0, 7'h00, 1'b0, 1'b1);
        checkOutput("reset_hex", 32'(hex_out), 32'h0);
        checkOutput("reset_upd_idx", 32'(upd_idx), 32'h0);

        // Single digit commit latency
        dut_upd = 0;
        hold(4'b0001, 7'h30, 6);
        checkOutput("t1_update_count", 32'(dut_upd), 32'd1);
        checkOutput("t1_hex0", 32'(hex_out[3:0]), 32'h1);

        // Full scan with blanking
        dut_upd = 0;
        hold(4'b1000, 7'h4E, 6); hold(4'b0000, 7'h00, 2);
        hold(4'b0100, 7'h7E, 6); hold(4'b0000, 7'h00, 2);
        hold(4'b0010, 7'h3D, 6); hold(4'b0000, 7'h00, 2);
        hold(4'b0001, 7'h4F, 6); hold(4'b0000, 7'h00, 2);
        checkOutput("t2_hex", 32'(hex_out), 32'hC0DE);
        checkOutput("t2_valid", 32'(digit_valid), 32'hF);
        checkOutput("t2_update_count", 32'(dut_upd), 32'd4);

        // Glitch shorter than the window
        hold(4'b0001, 7'h7F, 2);
        hold(4'b0001, 7'h7B, 6);
        checkOutput("t3_hex0", 32'(hex_out[3:0]), 32'h9);

        // Illegal pattern, clear, and clear colliding with a new illegal commit
        hold(4'b0000, 7'h00, 1);
        hold(4'b0100, 7'h01, 6);
        checkOutput("t4_valid2", 32'(digit_valid[2]), 32'h0);
        checkOutput("t4_err", 32'(pattern_err), 32'h1);
        checkOutput("t4_hex2", 32'(hex_out[11:8]), 32'h0);
        applyStimulus(4'b0000, 7'h00, 1'b1, 1'b0);
        checkOutput("t4_err_cleared", 32'(pattern_err), 32'h0);
        hold(4'b0100, 7'h00, 4);
        applyStimulus(4'b0100, 7'h00, 1'b1, 1'b0);
        checkOutput("t4_err_set_wins", 32'(pattern_err), 32'h1);
        applyStimulus(4'b0000, 7'h00, 1'b1, 1'b0);

        // Overlapping selects never commit
        dut_upd = 0;
        hold(4'b0011, 7'h30, 10);
        checkOutput("t5_update_count", 32'(dut_upd), 32'd0);

        // Long hold commits once; reset mid-window restarts the count
        dut_upd = 0;
        hold(4'b0001, 7'h5B, 20);
        checkOutput("t6_update_count", 32'(dut_upd), 32'd1);
        hold(4'b0010, 7'h33, 1);
        applyStimulus(4'b0010, 7'h33, 1'b0, 1'b1);
        checkOutput("t6_reset_hex", 32'(hex_out), 32'h0);
        checkOutput("t6_reset_valid", 32'(digit_valid), 32'h0);
        dut_upd = 0;
        hold(4'b0010, 7'h33, 6);
        checkOutput("t6_restart_count", 32'(dut_upd), 32'd1);

        // Randomised scanning traffic
        for (int s = 0; s < 300; s++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 60)      dsel = ND'(1 << $urandom_range(0, ND - 1));
            else if (pick < 75) dsel = '0;
            else                dsel = ND'($urandom_range(0, (1 << ND) - 1));
            if ($urandom_range(0, 9) < 8) seg = legal_pat[$urandom_range(0, 15)];
            else                          seg = 7'($urandom);
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                applyStimulus(dsel, seg, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
